// File: rtl/img_rsz_pxl_fwd.sv
// Resized pixel forwarder: walks the block-buffer executed flags in raster order, flushes
// each finished block and presents its pixel through a one-entry valid/ready output stage.
module img_rsz_pxl_fwd #(
  parameter int unsigned RSZ_W     = 4,
  parameter int unsigned RSZ_H     = 4,
  parameter int unsigned COLOR_NUM = 3,
  parameter int unsigned COLOR_W   = 8
) (
  input  logic                             Clk,
  input  logic                             Reset,
  input  logic                             FrmStart,
  input  logic [RSZ_H-1:0][RSZ_W-1:0]      BlkIsExec,
  input  logic [COLOR_NUM*COLOR_W-1:0]     FlushRszPxlData,
  output logic [RSZ_W-1:0]                 FlushBlkXMsk,
  output logic [RSZ_H-1:0]                 FlushBlkYMsk,
  output logic                             FlushVld,
  output logic [COLOR_NUM*COLOR_W-1:0]     RszPxlData,
  output logic [$clog2(RSZ_W)-1:0]         RszPxlX,
  output logic [$clog2(RSZ_H)-1:0]         RszPxlY,
  output logic                             RszPxlEol,
  output logic                             RszPxlLast,
  output logic                             RszPxlVld,
  input  logic                             RszPxlRdy,
  output logic                             FrmDone
);

  localparam int unsigned XW = $clog2(RSZ_W);
  localparam int unsigned YW = $clog2(RSZ_H);
  localparam int unsigned DW = COLOR_NUM * COLOR_W;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} stateT;

  stateT          state, stateNxt;
  logic [XW-1:0]  curX, curXNxt;
  logic [YW-1:0]  curY, curYNxt;
  logic [DW-1:0]  dataNxt;
  logic [XW-1:0]  pxXNxt;
  logic [YW-1:0]  pxYNxt;
  logic           eolNxt, lastNxt, vldNxt, doneNxt;
  logic           take, handshake, curXEnd, curYEnd;

  assign curXEnd      = (curX == XW'(RSZ_W - 1));
  assign curYEnd      = (curY == YW'(RSZ_H - 1));
  assign handshake    = RszPxlVld & RszPxlRdy;
  // A block is taken only when its flag is set and the output stage can accept it this cycle.
  assign take         = (state == SCAN) & BlkIsExec[curY][curX] & (~RszPxlVld | RszPxlRdy);
  assign FlushVld     = take;
  assign FlushBlkXMsk = RSZ_W'(1) << curX;
  assign FlushBlkYMsk = RSZ_H'(1) << curY;

  // Next-state, cursor and output-stage logic
  always_comb begin
    stateNxt = state;
    curXNxt  = curX;
    curYNxt  = curY;
    dataNxt  = RszPxlData;
    pxXNxt   = RszPxlX;
    pxYNxt   = RszPxlY;
    eolNxt   = RszPxlEol;
    lastNxt  = RszPxlLast;
    vldNxt   = RszPxlVld & ~handshake;
    doneNxt  = 1'b0;

    unique case (state)
      IDLE: begin
        if (FrmStart) begin
          stateNxt = SCAN;
          curXNxt  = '0;
          curYNxt  = '0;
        end
      end
      SCAN: begin
        if (take) begin
          dataNxt = FlushRszPxlData;
          pxXNxt  = curX;
          pxYNxt  = curY;
          eolNxt  = curXEnd;
          lastNxt = curXEnd & curYEnd;
          vldNxt  = 1'b1;
          if (curXEnd) begin
            curXNxt = '0;
            if (curYEnd) begin
              curYNxt  = '0;
              stateNxt = DRAIN;
            end else begin
              curYNxt = curY + YW'(1);
            end
          end else begin
            curXNxt = curX + XW'(1);
          end
        end
      end
      DRAIN: begin
        if (handshake && RszPxlLast) begin
          stateNxt = IDLE;
          doneNxt  = 1'b1;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      curX       <= '0;
      curY       <= '0;
      RszPxlData <= '0;
      RszPxlX    <= '0;
      RszPxlY    <= '0;
      RszPxlEol  <= 1'b0;
      RszPxlLast <= 1'b0;
      RszPxlVld  <= 1'b0;
      FrmDone    <= 1'b0;
    end else begin
      state      <= stateNxt;
      curX       <= curXNxt;
      curY       <= curYNxt;
      RszPxlData <= dataNxt;
      RszPxlX    <= pxXNxt;
      RszPxlY    <= pxYNxt;
      RszPxlEol  <= eolNxt;
      RszPxlLast <= lastNxt;
      RszPxlVld  <= vldNxt;
      FrmDone    <= doneNxt;
    end
  end

endmodule

// File: tb/tb_img_rsz_pxl_fwd.sv
// Bench for img_rsz_pxl_fwd: directed frames plus randomized flag/ready traffic, checked
// every cycle against a raster-index reference model of the forwarder.
module tb_img_rsz_pxl_fwd;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 4;
  localparam int unsigned CN = 3;
  localparam int unsigned CW = 8;
  localparam int unsigned DW = CN * CW;
  localparam int unsigned XW = $clog2(W);
  localparam int unsigned YW = $clog2(H);
  localparam int unsigned N  = W * H;

  logic                  Clk = 1'b0;
  logic                  Reset, FrmStart, RszPxlRdy;
  logic [H-1:0][W-1:0]   BlkIsExec;
  logic [DW-1:0]         FlushRszPxlData;
  logic [W-1:0]          FlushBlkXMsk;
  logic [H-1:0]          FlushBlkYMsk;
  logic                  FlushVld, RszPxlEol, RszPxlLast, RszPxlVld, FrmDone;
  logic [DW-1:0]         RszPxlData;
  logic [XW-1:0]         RszPxlX;
  logic [YW-1:0]         RszPxlY;

  always #5 Clk = ~Clk;

  img_rsz_pxl_fwd #(.RSZ_W(W), .RSZ_H(H), .COLOR_NUM(CN), .COLOR_W(CW)) dut (
    .Clk(Clk), .Reset(Reset), .FrmStart(FrmStart), .BlkIsExec(BlkIsExec),
    .FlushRszPxlData(FlushRszPxlData), .FlushBlkXMsk(FlushBlkXMsk), .FlushBlkYMsk(FlushBlkYMsk),
    .FlushVld(FlushVld), .RszPxlData(RszPxlData), .RszPxlX(RszPxlX), .RszPxlY(RszPxlY),
    .RszPxlEol(RszPxlEol), .RszPxlLast(RszPxlLast), .RszPxlVld(RszPxlVld),
    .RszPxlRdy(RszPxlRdy), .FrmDone(FrmDone)
  );

  // Block buffer pixel store, muxed by the flush masks
  logic [DW-1:0] pix [N];
  always_comb begin
    FlushRszPxlData = '0;
    for (int i = 0; i < int'(N); i++)
      if (FlushBlkXMsk[i % W] && FlushBlkYMsk[i / W]) FlushRszPxlData = pix[i];
  end

  typedef struct { int idx; logic [DW-1:0] d; } pxT;

  int  cmpCnt = 0, errCnt = 0;
  int  doneSeen = 0, flushSeen = 0, hsCnt = 0;
  bit  mInFrame = 0, mDoneNext = 0;
  int  mFlushIdx = 0;
  pxT  q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    cmpCnt++;
    assert (obs === expv) else begin
      errCnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: check outputs at negedge against the model, advance model, apply flush to flags
  task automatic tick();
    bit expFlush, startNow, newDone, clr;
    int cx, cy;
    logic [W-1:0] clrX;
    logic [H-1:0] clrY;
    pxT p;
    @(negedge Clk);
    cx = (mInFrame && mFlushIdx < int'(N)) ? mFlushIdx % W : 0;
    cy = (mInFrame && mFlushIdx < int'(N)) ? mFlushIdx / W : 0;
    expFlush = mInFrame && (mFlushIdx < int'(N)) && BlkIsExec[cy][cx] && (q.size() == 0 || RszPxlRdy);
    chk("flush_vld", 64'(FlushVld), 64'(expFlush));
    chk("x_msk", 64'(FlushBlkXMsk), 64'(1) << cx);
    chk("y_msk", 64'(FlushBlkYMsk), 64'(1) << cy);
    chk("pxl_vld", 64'(RszPxlVld), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("pxl_data", 64'(RszPxlData), 64'(q[0].d));
      chk("pxl_x", 64'(RszPxlX), 64'(q[0].idx % W));
      chk("pxl_y", 64'(RszPxlY), 64'(q[0].idx / W));
      chk("pxl_eol", 64'(RszPxlEol), 64'((q[0].idx % W) == W - 1));
      chk("pxl_last", 64'(RszPxlLast), 64'(q[0].idx == int'(N) - 1));
    end
    chk("frm_done", 64'(FrmDone), 64'(mDoneNext));
    if (FrmDone) doneSeen++;
    if (FlushVld) flushSeen++;
    clr  = FlushVld;
    clrX = FlushBlkXMsk;
    clrY = FlushBlkYMsk;
    newDone = 0;
    if (Reset) begin
      q.delete();
      mInFrame  = 0;
      mFlushIdx = 0;
    end else begin
      startNow = !mInFrame && FrmStart;
      if (q.size() != 0 && RszPxlRdy) begin
        p = q.pop_front();
        hsCnt++;
        if (p.idx == int'(N) - 1) begin
          newDone  = 1;
          mInFrame = 0;
        end
      end
      if (expFlush) begin
        p.idx = mFlushIdx;
        p.d   = pix[mFlushIdx];
        q.push_back(p);
        mFlushIdx++;
      end
      if (startNow) begin
        mInFrame  = 1;
        mFlushIdx = 0;
      end
    end
    mDoneNext = newDone;
    @(posedge Clk);
    #1;
    if (clr)
      for (int y = 0; y < int'(H); y++)
        for (int x = 0; x < int'(W); x++)
          if (clrY[y] && clrX[x]) BlkIsExec[y][x] = 1'b0;
    FrmStart = 1'b0;
  endtask

  task automatic runFrame(input int budget, input bit rndRdy, input bit rndFlag);
    int target, rx, ry;
    target = doneSeen + 1;
    for (int c = 0; c < budget && doneSeen < target; c++) begin
      if (rndRdy) RszPxlRdy = ($urandom_range(0, 3) != 0);
      if (rndFlag && $urandom_range(0, 1) == 1) begin
        rx = $urandom_range(0, W - 1);
        ry = $urandom_range(0, H - 1);
        BlkIsExec[ry][rx] = 1'b1;
      end
      tick();
    end
    chk("frame_done_cnt", 64'(doneSeen), 64'(target));
  endtask

  task automatic newPix();
    for (int i = 0; i < int'(N); i++) pix[i] = DW'($urandom());
  endtask

  task automatic startFrame();
    hsCnt    = 0;
    FrmStart = 1'b1;
    tick();
  endtask

  initial begin
    int base;
    Reset     = 1'b1;
    FrmStart  = 1'b0;
    RszPxlRdy = 1'b1;
    BlkIsExec = '1;
    newPix();
    @(posedge Clk);
    #1;
    tick();
    chk("rst_vld", 64'(RszPxlVld), 64'(0));
    chk("rst_data", 64'(RszPxlData), 64'(0));
    Reset = 1'b0;

    // 1: idle with all flags set, no frame start
    base = flushSeen;
    repeat (20) tick();
    chk("idle_no_flush", 64'(flushSeen - base), 64'(0));

    // 2: full frame with Rdy=1
    newPix();
    BlkIsExec = '1;
    base = flushSeen;
    startFrame();
    runFrame(40, 0, 0);
    chk("frm_flushes", 64'(flushSeen - base), 64'(N));
    chk("frm_pixels", 64'(hsCnt), 64'(N));
    repeat (3) tick();

    // 3: out-of-order flags wait for the cursor
    newPix();
    BlkIsExec = '0;
    base = flushSeen;
    startFrame();
    tick();
    BlkIsExec[0][1] = 1'b1;
    repeat (8) tick();
    chk("no_early_flush", 64'(flushSeen - base), 64'(0));
    BlkIsExec[0][0] = 1'b1;
    repeat (4) tick();
    chk("two_flushes", 64'(flushSeen - base), 64'(2));
    for (int i = 2; i < int'(N); i++) BlkIsExec[i / W][i % W] = 1'b1;
    runFrame(60, 0, 0);

    // 4: backpressure holds the output stage
    newPix();
    pix[0] = 24'hA5A5A5;
    BlkIsExec = '1;
    startFrame();
    tick();
    RszPxlRdy = 1'b0;
    base = flushSeen;
    repeat (5) tick();
    chk("bp_data", 64'(RszPxlData), 64'(24'hA5A5A5));
    chk("bp_no_flush", 64'(flushSeen - base), 64'(0));
    RszPxlRdy = 1'b1;
    runFrame(40, 0, 0);

    // 5: reset mid-frame, then restart
    newPix();
    BlkIsExec = '1;
    startFrame();
    for (int c = 0; c < 40 && hsCnt < 7; c++) tick();
    chk("pre_rst_pixels", 64'(hsCnt), 64'(7));
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("mrst_vld", 64'(RszPxlVld), 64'(0));
    chk("mrst_data", 64'(RszPxlData), 64'(0));
    chk("mrst_xy", 64'({RszPxlX, RszPxlY}), 64'(0));
    chk("mrst_eol_last", 64'({RszPxlEol, RszPxlLast}), 64'(0));
    BlkIsExec = '1;
    startFrame();
    runFrame(40, 0, 0);

    // 6: FrmStart during SCAN is ignored
    newPix();
    BlkIsExec = '1;
    base = doneSeen;
    startFrame();
    for (int c = 0; c < 40 && hsCnt < 5; c++) tick();
    FrmStart = 1'b1;
    runFrame(40, 0, 0);
    chk("ign_pixels", 64'(hsCnt), 64'(N));
    repeat (6) tick();
    chk("ign_one_done", 64'(doneSeen - base), 64'(1));

    // Random flags and ready
    for (int f = 0; f < 6; f++) begin
      newPix();
      BlkIsExec = (W * H)'($urandom());
      startFrame();
      runFrame(600, 1, 1);
      chk("rnd_pixels", 64'(hsCnt), 64'(N));
    end
    RszPxlRdy = 1'b1;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
    $finish;
  end

endmodule
